// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave front end: deserializes MOSI command frames for the RAM
// and serializes RAM read data onto MISO.
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  output logic                 MISO
);

  localparam int WORD_W    = ADDR_SIZE + 2;
  localparam int BIT_CNT_W = $clog2(WORD_W);
  localparam int TX_CNT_W  = $clog2(ADDR_SIZE) + 1;
  localparam logic [BIT_CNT_W-1:0] LAST_RX_BIT = BIT_CNT_W'(WORD_W - 1);
  localparam logic [TX_CNT_W-1:0]  LAST_TX_BIT = TX_CNT_W'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [WORD_W-1:0]      shift_reg;
  logic [WORD_W-1:0]      rx_word;
  logic                   rx_done;
  logic                   rd_addr_seen;
  logic                   tx_captured;
  logic                   tx_done;
  logic [TX_CNT_W-1:0]    tx_cnt;
  logic [ADDR_SIZE-1:0]   tx_shift;
  logic                   shift_in;
  logic                   tx_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (SS_n) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI) begin
            next_state = WRITE;
          end else if (rd_addr_seen) begin
            next_state = READ_DATA;
          end else begin
            next_state = READ_ADD;
          end
        end
        default: next_state = state;
      endcase
    end
  end

  assign rx_word  = {shift_reg[WORD_W-2:0], MOSI};
  assign shift_in = (state == WRITE || state == READ_ADD || state == READ_DATA) && !rx_done;
  // The cycle carrying our own rx_valid is skipped so a stale tx_valid cannot capture old data.
  assign tx_phase = (state == READ_DATA) && rx_done && !rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_done      <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_captured  <= 1'b0;
      tx_done      <= 1'b0;
      tx_cnt       <= '0;
      tx_shift     <= '0;
      MISO         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        bit_cnt     <= '0;
        shift_reg   <= '0;
        rx_done     <= 1'b0;
        tx_captured <= 1'b0;
        tx_done     <= 1'b0;
        tx_cnt      <= '0;
        tx_shift    <= '0;
        MISO        <= 1'b0;
      end else begin
        if (shift_in) begin
          shift_reg <= rx_word;
          if (bit_cnt == LAST_RX_BIT) begin
            rx_data  <= rx_word;
            rx_valid <= 1'b1;
            rx_done  <= 1'b1;
            bit_cnt  <= '0;
            if (state == READ_ADD) begin
              rd_addr_seen <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (tx_phase) begin
          if (!tx_captured) begin
            if (tx_valid) begin
              tx_captured <= 1'b1;
              MISO        <= tx_data[ADDR_SIZE-1];
              tx_shift    <= {tx_data[ADDR_SIZE-2:0], 1'b0};
              tx_cnt      <= '0;
            end
          end else if (!tx_done) begin
            if (tx_cnt == LAST_TX_BIT) begin
              MISO         <= 1'b0;
              tx_done      <= 1'b1;
              rd_addr_seen <= 1'b0;
            end else begin
              MISO     <= tx_shift[ADDR_SIZE-1];
              tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
              tx_cnt   <= tx_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench for spi_slave with a small behavioural RAM.
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       MISO;

  int total = 0;
  int bad   = 0;

  logic [9:0] rx_q[$];
  logic       miso_q[$];
  logic       miso_chk = 1'b0;
  int         edge_no  = 0;
  logic       prev_rv  = 1'b0;

  logic [7:0] mem [256];
  logic [7:0] wr_addr;
  logic [7:0] rd_addr;

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .MISO     (MISO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: registered read response, tx_valid held until the next write-type command.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (rx_valid) begin
      case (rx_data[9:8])
        2'b00: begin wr_addr <= rx_data[7:0]; tx_valid <= 1'b0; end
        2'b01: begin mem[wr_addr] <= rx_data[7:0]; tx_valid <= 1'b0; end
        2'b10: rd_addr <= rx_data[7:0];
        default: begin tx_data <= mem[rd_addr]; tx_valid <= 1'b1; end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples outputs 2 time units after each rising edge.
  initial begin
    logic [9:0] exp_w;
    logic       exp_b;
    forever begin
      @(posedge clk);
      #2;
      if (miso_chk) begin
        if (miso_q.size() == 0) begin
          chk("miso_queue_underflow", 32'd1, 32'd0);
        end else begin
          exp_b = miso_q.pop_front();
          chk("miso_bit", {31'd0, MISO}, {31'd0, exp_b});
        end
      end else begin
        chk("miso_idle_zero", {31'd0, MISO}, 32'd0);
      end
      if (rx_valid) begin
        chk("rx_valid_single", {31'd0, prev_rv}, 32'd0);
        chk("rx_valid_edge", edge_no, 32'd12);
        if (rx_q.size() == 0) begin
          chk("rx_unexpected", {22'd0, rx_data}, 32'hFFFF);
        end else begin
          exp_w = rx_q.pop_front();
          chk("rx_data", {22'd0, rx_data}, {22'd0, exp_w});
        end
      end
      prev_rv = rx_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic run_frame(input logic cmd, input logic [9:0] word, input int n_low,
                           input bit rd_frame, input logic [7:0] exp_miso,
                           input int chk_state, input bit close);
    logic m;
    if (n_low >= 12) rx_q.push_back(word);
    for (int e = 1; e <= n_low; e++) begin
      if (e == 2) m = cmd;
      else if (e >= 3 && e <= 12) m = word[12-e];
      else if (e > 12) m = 1'($urandom_range(0, 1));
      else m = 1'b0;
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = m;
      @(posedge clk);
      #1;
      edge_no = e;
      if (rd_frame && e >= 14 && e <= 21) begin
        miso_q.push_back(exp_miso[21-e]);
        miso_chk = 1'b1;
      end else begin
        miso_chk = 1'b0;
      end
      if (e == 3 && chk_state >= 0) chk("state_at_edge3", 32'(dut.state), chk_state);
    end
    if (close) begin
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(posedge clk);
      #1;
      edge_no  = 0;
      miso_chk = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", {22'd0, rx_data}, 32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_miso", {31'd0, MISO}, 32'd0);
    chk("reset_state", 32'(dut.state), 32'd0);
    chk("reset_rd_seen", {31'd0, dut.rd_addr_seen}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // writes: address A5 <- 3C, address 42 <- C3 (last one held 5 extra edges)
    run_frame(1'b0, 10'h0A5, 12, 1'b0, 8'h00, 2, 1'b1);
    run_frame(1'b0, 10'h13C, 12, 1'b0, 8'h00, -1, 1'b1);
    run_frame(1'b0, 10'h042, 12, 1'b0, 8'h00, -1, 1'b1);
    run_frame(1'b0, 10'h1C3, 17, 1'b0, 8'h00, -1, 1'b1);

    // read A5
    run_frame(1'b1, 10'h2A5, 12, 1'b0, 8'h00, 3, 1'b1);
    chk("rd_seen_after_rdaddr", {31'd0, dut.rd_addr_seen}, 32'd1);
    run_frame(1'b1, 10'h300, 22, 1'b1, 8'h3C, 4, 1'b1);
    chk("rd_seen_after_rddata", {31'd0, dut.rd_addr_seen}, 32'd0);

    // read 42 with tx_valid still high from the previous read, 3 extra hold edges
    run_frame(1'b1, 10'h242, 12, 1'b0, 8'h00, 3, 1'b1);
    run_frame(1'b1, 10'h300, 25, 1'b1, 8'hC3, 4, 1'b1);
    chk("rd_seen_after_stale_read", {31'd0, dut.rd_addr_seen}, 32'd0);

    // read-address aborted after 5 data bits
    run_frame(1'b1, 10'h2A5, 7, 1'b0, 8'h00, 3, 1'b1);
    chk("abort_state_idle", 32'(dut.state), 32'd0);
    chk("abort_rd_seen", {31'd0, dut.rd_addr_seen}, 32'd0);
    run_frame(1'b1, 10'h2A5, 12, 1'b0, 8'h00, 3, 1'b1);
    chk("rd_seen_after_retry", {31'd0, dut.rd_addr_seen}, 32'd1);
    run_frame(1'b1, 10'h300, 6, 1'b0, 8'h00, 4, 1'b1);
    chk("abort_rddata_keeps_seen", {31'd0, dut.rd_addr_seen}, 32'd1);

    // reset in the middle of the MISO shift (after edge 16, MISO = bit5 of 3C = 1)
    run_frame(1'b1, 10'h300, 16, 1'b1, 8'h3C, 4, 1'b0);
    #2;
    miso_chk = 1'b0;
    edge_no  = 0;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    #1;
    chk("midreset_miso", {31'd0, MISO}, 32'd0);
    chk("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("midreset_rx_data", {22'd0, rx_data}, 32'd0);
    chk("midreset_rd_seen", {31'd0, dut.rd_addr_seen}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_frame(1'b1, 10'h2A5, 12, 1'b0, 8'h00, 3, 1'b1);
    repeat (3) @(negedge clk);
    chk("rx_queue_drained", rx_q.size(), 32'd0);
    chk("miso_queue_drained", miso_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave front end that sits directly upstream of the single-port RAM in the SPI wrapper. It deserializes MOSI frames into 10-bit command words (`rx_data`) with a one-cycle `rx_valid` strobe for the RAM. For read-data frames it captures the RAM's 8-bit `tx_data` and serializes it onto MISO. It is a five-state FSM with a bit counter and a persistent "read address received" flag.

## Interface
- `ADDR_SIZE`, default 8: RAM address/data width. `rx_data` is `ADDR_SIZE+2` bits wide; `tx_data` is `ADDR_SIZE` bits wide.
- `clk` input 1: SPI clock, the single clock. All logic samples on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `SS_n` input 1: slave select, active low. High means no frame is in progress.
- `MOSI` input 1: serial data from the master, MSB first.
- `tx_data` input ADDR_SIZE: read data from the RAM.
- `tx_valid` input 1: RAM read data is valid. The RAM holds it high until its next non-read command.
- `rx_data` output ADDR_SIZE+2: command word to the RAM. Bits [9:8] are the opcode (00 write address, 01 write data, 10 read address, 11 read data).
- `rx_valid` output 1: one-cycle strobe marking a new `rx_data`.
- `MISO` output 1: serial read data to the master, MSB first.

## Operation
- Frame format: 1 command bit, then 10 data bits MSB first.
  - Command bit 0 selects a write frame. Command bit 1 selects a read frame.
  - The block does not check the command bit against data bit 9.
- The FSM has five states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- State transitions:
  - IDLE to CHK_CMD when `SS_n` is sampled low.
  - In CHK_CMD, `MOSI` is sampled as the command bit and the next state is chosen:
    - 0 goes to WRITE.
    - 1 with `rd_addr_seen`=0 goes to READ_ADD.
    - 1 with `rd_addr_seen`=1 goes to READ_DATA.
  - From any state, `SS_n` sampled high goes to IDLE. This also clears the bit counter, the shift register and the tx-capture flag.
- WRITE and READ_ADD:
  - Shift 10 bits into a shift register, counting 0 to 9.
  - On the 10th bit, load `rx_data` with the shifted word including the current MOSI bit, and pulse `rx_valid` for one cycle.
  - Then hold in the state, ignoring MOSI, until `SS_n` goes high.
  - A READ_ADD frame sets `rd_addr_seen`=1 only when its 10th bit completes.
- READ_DATA:
  - Shift 10 bits and strobe `rx_valid` the same way as the other frames.
  - Then wait for `tx_valid`. The first cycle it is sampled high, latch `tx_data` into the out-shift register and set the captured flag.
  - The block captures at most once per frame. `tx_valid` stays high afterwards; this must not reload the register.
  - Shift out `ADDR_SIZE` bits MSB first. After the last bit, clear `rd_addr_seen`, drive MISO to 0, and hold until `SS_n` goes high.
- `rd_addr_seen` rules:
  - Cleared only by reset or by a completed READ_DATA transfer.
  - An aborted frame (`SS_n` rising early) leaves it unchanged.
- `tx_valid` is ignored in every state other than READ_DATA after its `rx_valid`.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `MISO`=0, state IDLE, `rd_addr_seen`=0, counters 0.
- Reset mid-frame takes effect immediately and aborts the frame.
- Frame cycle numbering counts edges with `SS_n` low, starting at 1:
  - Edge 1 is the IDLE to CHK_CMD transition.
  - Edge 2 samples the command bit.
  - Edges 3–12 sample data bits 9..0.
  - `rx_valid` is high during the cycle after edge 12.
- Read-data path:
  - The RAM registers its response, so `tx_valid` is first sampled high at edge 14.
  - MISO carries `tx_data[7]` after edge 14 and `tx_data[0]` after edge 21.
  - The master samples MISO on posedge at edges 15–22.
  - A minimum READ_DATA frame is 22 edges with `SS_n` low, then `SS_n` high.
- If `tx_valid` is already high when `rx_valid` fires (stale from a prior read), the block still waits until the cycle after its own `rx_valid` before capturing. The capture point is therefore edge 14 in all cases.
- `rx_valid` is never high for two consecutive cycles.
- Back-to-back frames: `SS_n` high for one edge (return to IDLE), then low again is legal.

## Test plan
- Write address: reset, then frame with command bit 0 and data `00_1010_0101`. Required: `rx_data`=0x0A5 and `rx_valid` high for exactly 1 cycle after edge 12; MISO=0 throughout.
- Full write/read: write-address 0x0A5, write-data `01_0011_1100` (0x13C), read-address `10_1010_0101` (0x2A5), then read-data `11_xxxxxxxx`. Required: RAM returns 0x3C; MISO shifts 0,0,1,1,1,1,0,0 on edges 15–22; `rd_addr_seen` is 0 after the read-data frame.
- Read-address aborted by `SS_n` high after 5 data bits. Required: no `rx_valid`, FSM in IDLE. The next frame with command 1 enters READ_ADD, not READ_DATA.
- Reset asserted during the MISO shift of a read-data frame. Required: `MISO`, `rx_valid` and `rx_data` go to 0 immediately, and `rd_addr_seen`=0 afterwards.
- Second read-data frame while `tx_valid` is still high from the prior read, after a fresh read-address. Required: capture happens at edge 14 with the new RAM data, and MISO is loaded only once per frame.
- `SS_n` held low 5 extra edges after a write frame completes. Required: no extra `rx_valid`; MOSI toggling is ignored.
